lcm_div_64: RTL
===============

LCM_DIV_64 -- requirements
Module: lcm_div_64

Interface
REQ-001 Parameter W, default 64, operand width in bits; result width is 2*W.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ina  input  W  first operand, the same value presented to gcd_64.
REQ-005 inb  input  W  second operand, the same value presented to gcd_64.
REQ-006 g  input  W  gcd(ina, inb), taken from gcd_64 result.
REQ-007 g_ready_n  input  1  gcd_64 ready_n; low means g is valid.
REQ-008 result  output  2*W  lcm(ina, inb) = (ina / g) * inb.
REQ-009 ready_n  output  1  low means result is valid.
REQ-010 err  output  1  high means g = 0 or g does not divide ina exactly.

Function
REQ-011 States SHALL be IDLE, DIV, MUL and DONE.
REQ-012 In IDLE, on the first rising edge sampling g_ready_n = 0, the block SHALL latch ina, inb and g.
  - g != 0: go to DIV with step counter 0.
  - g = 0: go to DONE with result 0 and err 1.
REQ-013 DIV SHALL run one restoring shift-subtract step per cycle for exactly W cycles, giving a W-bit quotient q = ina/g and a remainder r.
REQ-014 At DIV exit, err SHALL be set to (r != 0), and the state SHALL go to MUL with the counter cleared.
REQ-015 MUL SHALL run one shift-add step per cycle for exactly W cycles, forming the 2*W-bit product q*inb with no truncation.
REQ-016 On the last MUL edge the state SHALL go to DONE, with result and ready_n = 0 registered on that same edge.
REQ-017 Latency SHALL be as follows.
  - g != 0: ready_n falls exactly 2*W clock edges after the capture edge (128 for W = 64).
  - g = 0: ready_n falls on the capture edge.
REQ-018 In DONE, result, err and ready_n = 0 SHALL hold until g_ready_n is sampled high, then the state SHALL return to IDLE with ready_n = 1 on that edge.
REQ-019 Changes on ina, inb, g and g_ready_n in DIV and MUL SHALL be ignored; only the latched copies are used.
REQ-020 ina = 0 or inb = 0 with g != 0 SHALL give result 0 and err 0.
REQ-021 g_ready_n held low continuously SHALL NOT retrigger a computation after DONE; a high level must be seen first.
REQ-022 result SHALL read 0 at all times other than DONE.

Reset
REQ-023 rst_n = 0 SHALL immediately force the following, regardless of state, including mid-DIV or mid-MUL.
  - State IDLE.
  - result 0, ready_n 1, err 0.
  - Counters and latched operands 0.
REQ-024 After rst_n rises, the block SHALL wait in IDLE for a fresh g_ready_n low sample, matching the gcd_64 rst_n-as-start protocol.

Structure
REQ-025 A shared package lcm_pkg SHALL hold W, the state enumeration typedef, and the constants DIV_CYCLES = W and MUL_CYCLES = W.
REQ-026 The W-step restoring divider SHALL be a separate sub-module udiv_seq with a start/done handshake.
REQ-027 MUL and the control FSM SHALL remain in lcm_div_64.

Verification
REQ-028 ina = 640, inb = 120, g = 40, g_ready_n falls -> result 1920, err 0, ready_n low 128 edges after capture.
REQ-029 ina = 2502, inb = 122, g = 2 -> result 152622, err 0; then ina = 1402, inb = 291, g = 1 -> result 407982, err 0.
REQ-030 ina = inb = 2^64-1, g = 1 -> result 0xFFFFFFFFFFFFFFFE0000000000000001, err 0.
REQ-031 ina = 0, inb = 0, g = 0 -> result 0, err 1, ready_n low on the capture edge.
REQ-032 ina = 10, inb = 5, g = 3 (inconsistent) -> result 15, err 1.
REQ-033 rst_n pulsed low at edge 70 of a computation -> outputs at reset values immediately; after rst_n rises and a new g_ready_n falls, the next result is correct with full 128-edge latency.

Source files
------------

// File: rtl/lcm_pkg.sv
// lcm_pkg: shared width, FSM states and step counts for the lcm_div_64 datapath
package lcm_pkg;
  localparam int W = 64;
  localparam int DIV_CYCLES = W;
  localparam int MUL_CYCLES = W;
  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;
endpackage

// File: rtl/udiv_seq.sv
// udiv_seq: restoring divider, one quotient bit per cycle, W cycles after start
module udiv_seq #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W);
  logic [W-1:0] d, dv, r;
  logic [CW-1:0] cnt;
  logic busy;
  logic [W:0] t;
  logic ge;
  // quo/rem are the post-step values; they are final while done is high
  always_comb begin
    t = {r, d[W-1]};
    ge = t >= {1'b0, dv};
    quo = {d[W-2:0], ge};
    rem = ge ? W'(t - {1'b0, dv}) : t[W-1:0];
    done = busy && cnt == CW'(W - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
      dv <= '0;
      r <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      d <= dividend;
      dv <= divisor;
      r <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      d <= quo;
      r <= rem;
      cnt <= cnt + CW'(1);
      busy <= !done;
    end
  end
endmodule

// File: rtl/lcm_div_64.sv
// lcm_div_64: lcm(ina, inb) = (ina / g) * inb using a serial divider then a serial multiplier
module lcm_div_64
  import lcm_pkg::*;
#(
  parameter int W = lcm_pkg::W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   ina,
  input  logic [W-1:0]   inb,
  input  logic [W-1:0]   g,
  input  logic           g_ready_n,
  output logic [2*W-1:0] result,
  output logic           ready_n,
  output logic           err
);
  localparam int CW = $clog2(MUL_CYCLES);
  state_t state, state_nx;
  logic cap, start, div_done, mul_last;
  logic [W-1:0] quo, rem, mp;
  logic [2*W-1:0] mc, acc, acc_nx;
  logic [CW-1:0] cnt;
  udiv_seq #(.W(W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(ina),
    .divisor(g),
    .done(div_done),
    .quo(quo),
    .rem(rem)
  );
  always_comb begin
    cap = state == IDLE && !g_ready_n;
    start = cap && g != '0;
    mul_last = cnt == CW'(MUL_CYCLES - 1);
    acc_nx = acc + (mp[0] ? mc : '0);
    state_nx = state == IDLE ? (cap ? (start ? DIV : DONE) : IDLE) :
               state == DIV  ? (div_done ? MUL : DIV) :
               state == MUL  ? (mul_last ? DONE : MUL) :
                               (g_ready_n ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // g = 0 skips straight to DONE with err set and result left at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      ready_n <= 1'b1;
      err <= 1'b0;
      mp <= '0;
      mc <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cap) begin
          mp <= inb;
          err <= !start;
          ready_n <= start;
        end
        DIV: if (div_done) begin
          err <= rem != '0;
          mc <= {{W{1'b0}}, quo};
          acc <= '0;
          cnt <= '0;
        end
        MUL: begin
          acc <= acc_nx;
          mc <= mc << 1;
          mp <= mp >> 1;
          cnt <= cnt + CW'(1);
          if (mul_last) begin
            result <= acc_nx;
            ready_n <= 1'b0;
          end
        end
        DONE: if (g_ready_n) begin
          result <= '0;
          ready_n <= 1'b1;
          err <= 1'b0;
        end
      endcase
    end
  end
endmodule
